bus_host_arbiter: RTL

Round-robin arbiter sharing one device-side memory bus port among `NrHosts` bus hosts: the core instruction port, the core data port and the debug module. It sits between the hosts and the SRAM/peripheral crossbar of the demo system. It holds each arbitration decision stable until the device grants, and tracks up to two outstanding transactions so every response is routed back to the host that issued it.

---
 rtl/bus_arb_pkg.sv | 8 +
 rtl/bus_arb_id_fifo.sv | 38 +++
 rtl/bus_host_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and constants for the bus host arbiter.
package bus_arb_pkg;
    typedef enum logic {IDLE, HOLD} bus_arb_state_e;
    localparam int BusArbFifoDepth = 2;
    function automatic int id_width(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/bus_arb_id_fifo.sv
// bus_arb_id_fifo: 2-entry FIFO of granted host IDs awaiting their responses.
module bus_arb_id_fifo
    import bus_arb_pkg::*;
#(
    parameter int IdW = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           push_i,
    input  logic           pop_i,
    input  logic [IdW-1:0] id_i,
    output logic           full_o,
    output logic           empty_o,
    output logic [IdW-1:0] head_o
);
    logic [IdW-1:0] mem_q [BusArbFifoDepth];
    logic           rd_ptr_q, wr_ptr_q;
    logic [1:0]     cnt_q;

    assign full_o  = (cnt_q == 2'(BusArbFifoDepth));
    assign empty_o = (cnt_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];

    // When full, push with pop writes the slot being read; the head is consumed this cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) mem_q[wr_ptr_q] <= id_i;
            wr_ptr_q <= wr_ptr_q ^ push_i;
            rd_ptr_q <= rd_ptr_q ^ pop_i;
            cnt_q    <= cnt_q + 2'(push_i) - 2'(pop_i);
        end
    end
endmodule

// File: rtl/bus_host_arbiter.sv
// bus_host_arbiter: round-robin arbiter of NrHosts bus hosts onto one device port.
// Define BUS_ARB_FIXED_PRIO_EN for fixed priority (lowest host index wins).
module bus_host_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NrHosts   = 3,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                             clk_sys_i,
    input  logic                             rst_sys_i,
    input  logic [NrHosts-1:0]               host_req_i,
    input  logic [NrHosts-1:0]               host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0]   host_be_i,
    input  logic [NrHosts*AddrWidth-1:0]     host_addr_i,
    input  logic [NrHosts*DataWidth-1:0]     host_wdata_i,
    output logic [NrHosts-1:0]               host_gnt_o,
    output logic [NrHosts-1:0]               host_rvalid_o,
    output logic [DataWidth-1:0]             host_rdata_o,
    output logic                             host_err_o,
    output logic                             dev_req_o,
    output logic                             dev_we_o,
    output logic [DataWidth/8-1:0]           dev_be_o,
    output logic [AddrWidth-1:0]             dev_addr_o,
    output logic [DataWidth-1:0]             dev_wdata_o,
    input  logic                             dev_gnt_i,
    input  logic                             dev_rvalid_i,
    input  logic [DataWidth-1:0]             dev_rdata_i,
    input  logic                             dev_err_i,
    output logic                             protocol_err_o
);
    localparam int IdW = id_width(NrHosts);
    localparam int BeW = DataWidth / 8;

    bus_arb_state_e state_q, state_d;
    logic [IdW-1:0] hold_id_q, hold_id_d, prio_q, rr_id, cand, fifo_head;
    logic           perr_q, fifo_full, fifo_empty, fifo_pop, req, gnt, rsp;

`ifdef BUS_ARB_FIXED_PRIO_EN
    assign prio_q = '0;
`else
    logic [IdW-1:0] prio_d;
    assign prio_d = gnt ? ((cand == IdW'(NrHosts - 1)) ? '0 : cand + 1'b1) : prio_q;
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) prio_q <= '0;
        else prio_q <= prio_d;
    end
`endif

    always_comb begin
        rr_id = '0;
        for (int k = NrHosts - 1; k >= 0; k--)
            if (host_req_i[(int'(prio_q) + k) % NrHosts]) rr_id = IdW'((int'(prio_q) + k) % NrHosts);
    end

    // A pop in the same cycle frees the slot, so a full FIFO may still accept a grant.
    assign fifo_pop = dev_rvalid_i && !fifo_empty && !rst_sys_i;
    assign cand     = (state_q == HOLD) ? hold_id_q : rr_id;
    assign req      = !rst_sys_i && (!fifo_full || fifo_pop) && (state_q == HOLD || |host_req_i);
    assign gnt      = req && dev_gnt_i;
    assign rsp      = fifo_pop;

    always_comb begin
        state_d   = ((state_q == HOLD || req) && !gnt) ? HOLD : IDLE;
        hold_id_d = (state_q == IDLE && req && !gnt) ? rr_id : hold_id_q;
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q   <= IDLE;
            hold_id_q <= '0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_id_q <= hold_id_d;
            perr_q    <= perr_q | (dev_rvalid_i & fifo_empty);
        end
    end

    bus_arb_id_fifo #(.IdW(IdW)) u_id_fifo (
        .clk_i   (clk_sys_i),
        .rst_i   (rst_sys_i),
        .push_i  (gnt),
        .pop_i   (fifo_pop),
        .id_i    (cand),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign dev_req_o      = req;
    assign dev_we_o       = req & host_we_i[cand];
    assign dev_be_o       = req ? host_be_i[cand*BeW +: BeW] : '0;
    assign dev_addr_o     = req ? host_addr_i[cand*AddrWidth +: AddrWidth] : '0;
    assign dev_wdata_o    = req ? host_wdata_i[cand*DataWidth +: DataWidth] : '0;
    assign host_gnt_o     = gnt ? (NrHosts'(1) << cand) : '0;
    assign host_rvalid_o  = rsp ? (NrHosts'(1) << fifo_head) : '0;
    assign host_rdata_o   = rsp ? dev_rdata_i : '0;
    assign host_err_o     = rsp & dev_err_i;
    assign protocol_err_o = perr_q;
endmodule
